instr_mem_fifo: RTL and testbench
=================================

Name: instr_mem_fifo

Overview:
Parametrised successor to the 8-entry instruction store that feeds the lab ALU.
- Holds up to DEPTH instruction words, each {opcode, operand A, operand B}, in a circular buffer.
- Words are loaded and consumed one per key press.
- Generalises the old block in word widths and depth, and adds independent read and write pointers, occupancy count, an internal key edge detector and a synchronous clear.
- Sits between the board synchroniser/clock divider and the ALU datapath.

Parameters:
- OP_W, 3, opcode width.
- OPND_W, 6, width of each operand A and B.
- DEPTH, 8, number of instruction entries; legal range is 2 or more; power of two is not required.
- ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  divided system clock.
- rst  in  1  asynchronous, active-high reset.
- key  in  1  synchronised push-button level, active-high; one press is one step.
- rw  in  1  0 = read (consume), 1 = write (load); sampled on the step cycle.
- clr  in  1  synchronous clear of pointers and count.
- i_data  in  OP_W+2*OPND_W  word to load, as {opcode, A, B}.
- instruction  out  OP_W  opcode of the last word read.
- A  out  OPND_W  operand A of the last word read.
- B  out  OPND_W  operand B of the last word read.
- out_address  out  ADDR_W  address of the last word read or written.
- count  out  ADDR_W+1  number of stored words.
- full  out  1  asserted when count == DEPTH.
- empty  out  1  asserted when count == 0.
- valid  out  1  instruction, A and B hold a word actually read.
- ovf  out  1  sticky write-when-full flag (optional feature).
- unf  out  1  sticky read-when-empty flag (optional feature).

Behaviour:
- Reset (async, rst=1): wp, rp, count, instruction, A, B, out_address, valid, ovf and unf all go to 0; the key edge register goes to 0; memory array is cleared to 0. Outputs must read 0 while rst is high.
- Step detection: step = key & ~key_q, where key_q is registered every clk. A held key gives exactly one step.
- Priority per cycle: rst > clr > step.
- clr: wp, rp and count go to 0. valid goes to 0. Memory contents, data outputs and error flags are kept.
- Write step (rw=1, !full):
  - mem[wp] <= i_data; out_address <= wp.
  - wp advances; it wraps from DEPTH-1 to 0 explicitly.
  - count increments.
- Write step when full: no memory or pointer change; ovf is set.
- Read step (rw=0, !empty):
  - {instruction, A, B} <= mem[rp]; out_address <= rp; valid <= 1.
  - rp advances with the same wrap rule; count decrements.
- Read step when empty: outputs hold; valid holds; unf is set.
- Latency: outputs, count and flags update on the clk edge after the first cycle key is sampled high. That is one cycle from step detection to visible data.
- full and empty are decoded combinationally from count. Because count is registered, they change in the same cycle as count.
- Occupancy states derived from count: EMPTY -> PARTIAL on a write; PARTIAL -> FULL when a write reaches DEPTH; FULL -> PARTIAL on a read; PARTIAL -> EMPTY when a read reaches 0. Illegal transitions do not exist.
- rw may change at any time; only its value on the step cycle matters.
- Wrap-around: after DEPTH writes and DEPTH reads, wp = rp = 0 with count = 0. This is distinguished from full by count, not by the pointers.
- Reset mid-operation (including a held key): after release there is no spurious step until key goes low and then high again.

Optional Feature:
Macro: INSTR_MEM_ERR_EN
- Defined: ovf and unf behave as described above, are sticky, and are cleared only by rst.
- Undefined: ovf and unf are tied to 0; overflow writes and underflow reads are silently ignored. All other behaviour is identical.

Decomposition:
- Package instr_mem_pkg holds:
  - default constants OP_W_DEF=3 and OPND_W_DEF=6;
  - a parametrised packed struct typedef instr_t {opcode, a, b}, built from the defaults;
  - the count helper function.
- One sub-module, key_edge_det: holds the key_q register, outputs the step pulse, and resets asynchronously on rst.
- The pointer, count and storage logic stays in instr_mem_fifo.

Test Plan:
- Reset: hold rst mid-cycle -> all outputs 0, empty=1, count=0 immediately, asynchronously.
- Load and read, DEPTH=8: write 0x1041, 0x2FC3, 0x7FFF, then read three times -> instruction/A/B = 1/1/1, 2/63/3, 7/63/63; out_address = 0,1,2; empty=1 at the end.
- Full boundary: 8 writes -> full=1, count=8. A 9th write -> no change and ovf=1 (with macro) or ovf=0 (without). Then 8 reads return the words in write order.
- Wrap-around: 6 writes, 6 reads, 4 writes, 4 reads -> second-batch addresses are 6,7,0,1 and the data matches.
- Empty read: read after reset -> valid=0, outputs 0, unf=1 (with macro).
- Held key / clr: key held high for 10 cycles with rw=1 -> exactly one write. Then clr pulsed in the same cycle as a step -> count=0, no write.

Source files
------------

// File: rtl/instr_mem_fifo_pkg.sv
// Shared defaults, instruction word layout and occupancy helper for instr_mem_fifo.
package instr_mem_pkg;

    localparam int OP_W_DEF   = 3;
    localparam int OPND_W_DEF = 6;

    typedef struct packed {
        logic [OP_W_DEF-1:0]   opcode;
        logic [OPND_W_DEF-1:0] a;
        logic [OPND_W_DEF-1:0] b;
    } instr_t;

    // Occupancy after one cycle; a simultaneous load and consume leaves it unchanged.
    function automatic logic [31:0] count_next(input logic [31:0] cnt,
                                               input logic        inc,
                                               input logic        dec);
        logic [31:0] res;
        res = cnt;
        if (inc && !dec)
            res = cnt + 32'd1;
        else if (dec && !inc)
            res = cnt - 32'd1;
        return res;
    endfunction

endpackage

// File: rtl/instr_mem_fifo_key_edge.sv
// Key press step detector: one pulse per rising edge of the synchronised key level.
module key_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_step
);

    logic r_key_q;
    logic r_armed;

    // Armed only once the key has been seen low, so a key held through reset gives no step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_key_q <= i_key;
            if (!i_key)
                r_armed <= 1'b1;
        end
    end

    assign o_step = i_key & ~r_key_q & r_armed;

endmodule

// File: rtl/instr_mem_fifo.sv
// Circular instruction store loaded/consumed one word per key press.
// Optional sticky overflow/underflow flags enabled by defining INSTR_MEM_ERR_EN.
module instr_mem_fifo
    import instr_mem_pkg::*;
#(
    parameter  int OP_W   = OP_W_DEF,
    parameter  int OPND_W = OPND_W_DEF,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key,
    input  logic                     rw,
    input  logic                     clr,
    input  logic [OP_W+2*OPND_W-1:0] i_data,
    output logic [OP_W-1:0]          instruction,
    output logic [OPND_W-1:0]        A,
    output logic [OPND_W-1:0]        B,
    output logic [ADDR_W-1:0]        out_address,
    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     empty,
    output logic                     valid,
    output logic                     ovf,
    output logic                     unf
);

    localparam int DW = OP_W + 2*OPND_W;
    localparam int CW = ADDR_W + 1;

    logic              w_step;
    logic              w_wr;
    logic              w_rd;
    logic [DW-1:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [CW-1:0]     r_count;
    logic [OP_W-1:0]   r_instr;
    logic [OPND_W-1:0] r_a;
    logic [OPND_W-1:0] r_b;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH-1)) ? '0 : p + ADDR_W'(1);
    endfunction

    key_edge_det u_key_edge (
        .clk    (clk),
        .rst    (rst),
        .i_key  (key),
        .o_step (w_step)
    );

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign w_wr  = w_step & rw & ~full;
    assign w_rd  = w_step & ~rw & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_instr <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= i_data;
                r_addr      <= r_wp;
                r_wp        <= ptr_inc(r_wp);
            end else if (w_rd) begin
                {r_instr, r_a, r_b} <= r_mem[r_rp];
                r_addr  <= r_rp;
                r_valid <= 1'b1;
                r_rp    <= ptr_inc(r_rp);
            end
            r_count <= CW'(count_next(32'(r_count), w_wr, w_rd));
        end
    end

`ifdef INSTR_MEM_ERR_EN
    logic r_ovf;
    logic r_unf;

    // Sticky until reset; clr deliberately leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!clr && w_step) begin
            if (rw && full)
                r_ovf <= 1'b1;
            if (!rw && empty)
                r_unf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    assign instruction = r_instr;
    assign A           = r_a;
    assign B           = r_b;
    assign out_address = r_addr;
    assign count       = r_count;
    assign valid       = r_valid;

endmodule

// File: tb/tb_instr_mem_fifo.sv
// Self-checking bench for instr_mem_fifo (DEPTH=8, 3/6/6-bit words) with a queue reference model.
module tb_instr_mem_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        key;
    logic        rw;
    logic        clr;
    logic [14:0] i_data;
    logic [2:0]  instruction;
    logic [5:0]  A;
    logic [5:0]  B;
    logic [2:0]  out_address;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        valid;
    logic        ovf;
    logic        unf;

    instr_mem_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .rw          (rw),
        .clr         (clr),
        .i_data      (i_data),
        .instruction (instruction),
        .A           (A),
        .B           (B),
        .out_address (out_address),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .valid       (valid),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: stored words as a queue, pointers as plain modulo counters.
    logic [14:0] mq[$];
    int          m_wp;
    int          m_rp;
    logic [14:0] m_word;
    int          m_addr;
    logic        m_valid;
    logic        m_ovf;
    logic        m_unf;

    typedef struct {
        logic        c;
        logic        w;
        logic [14:0] d;
        logic [2:0]  e_op;
        logic [5:0]  e_a;
        logic [5:0]  e_b;
        logic [2:0]  e_addr;
        logic [3:0]  e_cnt;
        logic        e_valid;
        logic        e_empty;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wp = 0; m_rp = 0; m_word = '0; m_addr = 0;
        m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic w, input logic [14:0] d);
        if (c) begin
            mq.delete();
            m_wp = 0; m_rp = 0; m_valid = 1'b0;
        end else if (w) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d);
                m_addr = m_wp;
                m_wp = (m_wp + 1) % DEPTH;
            end else begin
`ifdef INSTR_MEM_ERR_EN
                m_ovf = 1'b1;
`endif
            end
        end else begin
            if (mq.size() > 0) begin
                m_word = mq.pop_front();
                m_addr = m_rp;
                m_rp = (m_rp + 1) % DEPTH;
                m_valid = 1'b1;
            end else begin
`ifdef INSTR_MEM_ERR_EN
                m_unf = 1'b1;
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instr"}, instruction, m_word[14:12]);
        chk({tag, ".A"},     A,           m_word[11:6]);
        chk({tag, ".B"},     B,           m_word[5:0]);
        chk({tag, ".addr"},  out_address, m_addr);
        chk({tag, ".count"}, count,       mq.size());
        chk({tag, ".full"},  full,        mq.size() == DEPTH);
        chk({tag, ".empty"}, empty,       mq.size() == 0);
        chk({tag, ".valid"}, valid,       m_valid);
        chk({tag, ".ovf"},   ovf,         m_ovf);
        chk({tag, ".unf"},   unf,         m_unf);
    endtask

    // One key press: key high for one cycle, low the next; rw/data scrambled afterwards.
    task automatic do_step(input logic c, input logic w, input logic [14:0] d);
        @(negedge clk);
        key = 1'b1; rw = w; clr = c; i_data = d;
        @(negedge clk);
        key = 1'b0; clr = 1'b0;
        rw = 1'($urandom); i_data = 15'($urandom);
        model_step(c, w, d);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b1, 15'h1041, 3'd0, 6'd0,  6'd0,  3'd0, 4'd1, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 15'h2FC3, 3'd0, 6'd0,  6'd0,  3'd1, 4'd2, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 15'h7FFF, 3'd0, 6'd0,  6'd0,  3'd2, 4'd3, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 15'h0000, 3'd1, 6'd1,  6'd1,  3'd0, 4'd2, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 15'h0000, 3'd2, 6'd63, 6'd3,  3'd1, 4'd1, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b0, 15'h0000, 3'd7, 6'd63, 6'd63, 3'd2, 4'd0, 1'b1, 1'b1};

        rst = 1'b1; key = 1'b0; rw = 1'b0; clr = 1'b0; i_data = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Read from empty store after reset.
        do_step(1'b0, 1'b0, 15'h0);
        check_all("empty_rd");
        hard_reset();

        for (int i = 0; i < 6; i++) begin
            do_step(vt[i].c, vt[i].w, vt[i].d);
            chk($sformatf("tbl%0d.instr", i), instruction, vt[i].e_op);
            chk($sformatf("tbl%0d.A", i),     A,           vt[i].e_a);
            chk($sformatf("tbl%0d.B", i),     B,           vt[i].e_b);
            chk($sformatf("tbl%0d.addr", i),  out_address, vt[i].e_addr);
            chk($sformatf("tbl%0d.count", i), count,       vt[i].e_cnt);
            chk($sformatf("tbl%0d.valid", i), valid,       vt[i].e_valid);
            chk($sformatf("tbl%0d.empty", i), empty,       vt[i].e_empty);
        end

        // Fill to full, attempt one more write, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            do_step(1'b0, 1'b1, 15'($urandom));
            check_all("fill");
        end
        chk("full_flag", full, 1'b1);
        chk("full_count", count, 4'd8);
        do_step(1'b0, 1'b1, 15'h5A5A);
`ifdef INSTR_MEM_ERR_EN
        chk("ovf_set", ovf, 1'b1);
`else
        chk("ovf_off", ovf, 1'b0);
`endif
        check_all("over_wr");
        for (int i = 0; i < DEPTH; i++) begin
            do_step(1'b0, 1'b0, 15'h0);
            check_all("drain");
        end

        // Wrap-around from a clean pointer state.
        hard_reset();
        for (int i = 0; i < 6; i++) do_step(1'b0, 1'b1, 15'($urandom));
        for (int i = 0; i < 6; i++) do_step(1'b0, 1'b0, 15'h0);
        check_all("wrap_mid");
        for (int i = 0; i < 4; i++) begin
            do_step(1'b0, 1'b1, 15'($urandom));
            chk($sformatf("wrap_wr%0d.addr", i), out_address, (6 + i) % DEPTH);
        end
        for (int i = 0; i < 4; i++) begin
            do_step(1'b0, 1'b0, 15'h0);
            chk($sformatf("wrap_rd%0d.addr", i), out_address, (6 + i) % DEPTH);
            check_all("wrap_rd");
        end

        // Held key gives exactly one write.
        @(negedge clk);
        key = 1'b1; rw = 1'b1; i_data = 15'h1234;
        repeat (10) @(negedge clk);
        key = 1'b0;
        model_step(1'b0, 1'b1, 15'h1234);
        check_all("held_key");
        chk("held_count", count, 4'd1);

        // clr coinciding with a write step wins.
        do_step(1'b1, 1'b1, 15'h0777);
        check_all("clr_step");
        chk("clr_count", count, 4'd0);

        // Reset while key is held: no spurious step on release.
        do_step(1'b0, 1'b1, 15'h0ABC);
        @(negedge clk);
        key = 1'b1; rw = 1'b1; i_data = 15'h0DEF;
        @(negedge clk);
        model_step(1'b0, 1'b1, 15'h0DEF);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_all("held_through_rst");
        key = 1'b0;
        do_step(1'b0, 1'b1, 15'h0321);
        check_all("after_rst_wr");

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            do_step(($urandom_range(0, 24) == 0), 1'($urandom), 15'($urandom));
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
